// File: rtl/multi_counter_bank.sv
// Bank of signed up/down event counters with an atomic snapshot and a
// valid/ready readout stream of the latched values, one channel per word.
module multi_counter_bank #(
  parameter int CHANNELS   = 4,
  parameter int RESOLUTION = 32,
  parameter int WORD_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               cumulative,
  input  logic                               wrap_mode,
  input  logic                               clear_on_snap,
  input  logic [RESOLUTION-1:0]              counter_max,
  input  logic [RESOLUTION-1:0]              counter_min,
  input  logic [CHANNELS*WORD_WIDTH-1:0]     signal,
  input  logic [CHANNELS*WORD_WIDTH-1:0]     nsignal,
  input  logic                               snap_req,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [RESOLUTION-1:0]              out_data,
  output logic [$clog2(CHANNELS):0]          out_chan,
  output logic                               out_ovf,
  output logic                               out_last
);

  localparam int EW    = RESOLUTION + WORD_WIDTH + 2;
  localparam int IDX_W = $clog2(CHANNELS) + 1;

  // state    | meaning
  // S_IDLE   | counting only, waiting for snap_req
  // S_LATCH  | bank captured, readout index being primed
  // S_STREAM | presenting bank words until the last one is accepted
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LATCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [CHANNELS-1:0][RESOLUTION-1:0]  cnt_q, cnt_d, bank_q, bank_d, upd_cnt;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d, bank_ovf_q, bank_ovf_d, upd_ovf;
  logic [CHANNELS*WORD_WIDTH-1:0]       prev_sig_q, prev_sig_d, prev_nsig_q, prev_nsig_d;
  logic [IDX_W-1:0]                     idx_q, idx_d, ld_idx;
  logic                                 busy_q, busy_d, out_valid_q, out_valid_d;
  logic [RESOLUTION-1:0]                out_data_q, out_data_d;
  logic [IDX_W-1:0]                     out_chan_q, out_chan_d;
  logic                                 out_ovf_q, out_ovf_d, out_last_q, out_last_d;
  logic signed [EW-1:0]                 max_x, min_x;

  assign max_x = $signed({{(EW-RESOLUTION){counter_max[RESOLUTION-1]}}, counter_max});
  assign min_x = $signed({{(EW-RESOLUTION){counter_min[RESOLUTION-1]}}, counter_min});

  // The sum is formed wide enough that a step past either bound is always seen.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WORD_WIDTH-1:0] sig_w, nsig_w;
    logic signed [EW-1:0]  delta, nxt;
    logic                  upd, hi, lo;

    assign sig_w  = signal[g*WORD_WIDTH +: WORD_WIDTH];
    assign nsig_w = nsignal[g*WORD_WIDTH +: WORD_WIDTH];
    assign delta  = $signed({{(EW-WORD_WIDTH){1'b0}}, sig_w})
                  - $signed({{(EW-WORD_WIDTH){1'b0}}, nsig_w});
    assign nxt    = $signed({{(EW-RESOLUTION){cnt_q[g][RESOLUTION-1]}}, cnt_q[g]}) + delta;
    assign upd    = enable & (cumulative
                  | (sig_w != prev_sig_q[g*WORD_WIDTH +: WORD_WIDTH])
                  | (nsig_w != prev_nsig_q[g*WORD_WIDTH +: WORD_WIDTH]));
    assign hi     = nxt > max_x;
    assign lo     = nxt < min_x;

    assign upd_cnt[g] = !upd ? cnt_q[g]
                      : hi   ? (wrap_mode ? counter_min : counter_max)
                      : lo   ? (wrap_mode ? counter_max : counter_min)
                      :        nxt[RESOLUTION-1:0];
    assign upd_ovf[g] = ovf_q[g] | (upd & (hi | lo | (nxt == max_x) | (nxt == min_x)));
  end

  assign ld_idx = out_valid_q ? idx_q + IDX_W'(1) : idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = upd_cnt;
    ovf_d       = upd_ovf;
    prev_sig_d  = signal;
    prev_nsig_d = nsignal;
    bank_d      = bank_q;
    bank_ovf_d  = bank_ovf_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_ovf_d   = out_ovf_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          bank_d     = upd_cnt;
          bank_ovf_d = upd_ovf;
          busy_d     = 1'b1;
          state_d    = S_LATCH;
          if (clear_on_snap) begin
            cnt_d = '0;
            ovf_d = '0;
          end
        end
      end
      S_LATCH: begin
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (!out_valid_q || out_ready) begin
          idx_d       = ld_idx;
          out_valid_d = 1'b1;
          out_chan_d  = ld_idx;
          out_last_d  = (ld_idx == IDX_W'(CHANNELS-1));
          for (int c = 0; c < CHANNELS; c++) begin
            if (ld_idx == IDX_W'(c)) begin
              out_data_d = bank_q[c];
              out_ovf_d  = bank_ovf_q[c];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ovf_q       <= '0;
      prev_sig_q  <= '0;
      prev_nsig_q <= '0;
      bank_q      <= '0;
      bank_ovf_q  <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      prev_sig_q  <= prev_sig_d;
      prev_nsig_q <= prev_nsig_d;
      bank_q      <= bank_d;
      bank_ovf_q  <= bank_ovf_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_ovf   = out_ovf_q;
  assign out_last  = out_last_q;

endmodule
